frac_search_nway: RTL

- Parametrised quarter-pel motion-search SAD engine.
- Accepts one block row per handshake: the current-block row plus NCAND filtered candidate rows.
- Accumulates a per-candidate SAD over BLK rows, then compares the candidates sequentially.
- Presents the winning candidate index, its SAD and every candidate's SAD on a valid/ready output port.
- Sits after the sub-pel interpolation filter and feeds the MV decision logic.

---
 rtl/frac_search_pkg.sv | 18 +
 rtl/frac_search_nway_row_sad.sv | 32 +++
 rtl/frac_search_nway.sv | 93 +++++++++
 3 files changed

// File: rtl/frac_search_pkg.sv
// Shared state encoding, default geometry and SAD width helper for the quarter-pel search engine.
package frac_search_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] CMP  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam int DEF_BLK   = 8;
   localparam int DEF_PIX_W = 8;
   localparam int DEF_NCAND = 6;

   // BLK*BLK samples of PIX_W bits each can never carry past this width.
   function automatic int sad_width(input int blk, input int pix_w);
      return pix_w + 2 * $clog2(blk);
   endfunction

endpackage

// File: rtl/frac_search_nway_row_sad.sv
// Combinational sum of |a-b| over one row, reduced through a balanced adder tree.
// Zero latency, no flow control: the result follows the inputs.
module row_sad #(
   parameter int BLK   = 8,
   parameter int PIX_W = 8,
   parameter int RW    = PIX_W + $clog2(BLK)
) (
   input  logic [BLK*PIX_W-1:0] i_a,
   input  logic [BLK*PIX_W-1:0] i_b,
   output logic [RW-1:0]        o_sad
);

   // Heap layout: node n sums children 2n+1 and 2n+2; leaves occupy BLK-1 .. 2*BLK-2.
   logic [RW-1:0] w_node [2*BLK-1];

   for (genvar p = 0; p < BLK; p++) begin : g_leaf
      logic [PIX_W-1:0] w_a;
      logic [PIX_W-1:0] w_b;
      logic [PIX_W-1:0] w_d;
      assign w_a = i_a[p*PIX_W +: PIX_W];
      assign w_b = i_b[p*PIX_W +: PIX_W];
      assign w_d = (w_a > w_b) ? (w_a - w_b) : (w_b - w_a);
      assign w_node[BLK-1+p] = RW'(w_d);
   end

   for (genvar n = 0; n < BLK-1; n++) begin : g_tree
      assign w_node[n] = w_node[2*n+1] + w_node[2*n+2];
   end

   assign o_sad = w_node[0];

endmodule

// File: rtl/frac_search_nway.sv
// Quarter-pel SAD search: accumulates BLK rows for NCAND candidates, then picks the minimum one per cycle.
// Result appears NCAND cycles after the last row; in_ready drops during compare/result, result held until out_ready.
module frac_search_nway
   import frac_search_pkg::*;
#(
   parameter int BLK   = DEF_BLK,
   parameter int PIX_W = DEF_PIX_W,
   parameter int NCAND = DEF_NCAND,
   parameter int IDX_W = $clog2(NCAND),
   parameter int SAD_W = sad_width(BLK, PIX_W)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BLK*PIX_W-1:0]     cur_row,
   input  logic [NCAND*BLK*PIX_W-1:0] cand_rows,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [IDX_W-1:0]         best_idx,
   output logic [SAD_W-1:0]         best_sad,
   output logic [NCAND*SAD_W-1:0]   all_sad
);

   localparam int RW    = PIX_W + $clog2(BLK);
   localparam int CNT_W = $clog2(BLK);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_row_cnt;
   logic [IDX_W-1:0] r_cmp_idx;
   logic [IDX_W-1:0] r_best_idx;
   logic [SAD_W-1:0] r_best_sad;
   logic [SAD_W-1:0] r_acc [NCAND];
   logic [RW-1:0]    w_rowsad [NCAND];
   logic             w_xfer;

   for (genvar c = 0; c < NCAND; c++) begin : g_cand
      row_sad #(.BLK(BLK), .PIX_W(PIX_W), .RW(RW)) u_row_sad (
         .i_a   (cur_row),
         .i_b   (cand_rows[c*BLK*PIX_W +: BLK*PIX_W]),
         .o_sad (w_rowsad[c])
      );
      assign all_sad[c*SAD_W +: SAD_W] = r_acc[c];
   end

   // Gated by reset so the producer never sees ready while the engine is held in reset.
   assign in_ready  = reset && ((r_state == IDLE) || (r_state == ACC));
   assign out_valid = (r_state == DONE);
   assign best_idx  = r_best_idx;
   assign best_sad  = r_best_sad;
   assign w_xfer    = in_valid && in_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_row_cnt  <= '0;
         r_cmp_idx  <= '0;
         r_best_idx <= '0;
         r_best_sad <= '0;
         for (int c = 0; c < NCAND; c++) r_acc[c] <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_xfer) begin
               for (int c = 0; c < NCAND; c++) r_acc[c] <= SAD_W'(w_rowsad[c]);
               r_row_cnt <= CNT_W'(1);
               r_state   <= ACC;
            end
            ACC: if (w_xfer) begin
               for (int c = 0; c < NCAND; c++) r_acc[c] <= r_acc[c] + SAD_W'(w_rowsad[c]);
               if (r_row_cnt == CNT_W'(BLK-1)) begin
                  r_row_cnt <= '0;
                  r_cmp_idx <= '0;
                  r_state   <= CMP;
               end else begin
                  r_row_cnt <= r_row_cnt + 1'b1;
               end
            end
            CMP: begin
               // Strict less-than keeps the lowest index on ties.
               if ((r_cmp_idx == '0) || (r_acc[r_cmp_idx] < r_best_sad)) begin
                  r_best_sad <= r_acc[r_cmp_idx];
                  r_best_idx <= r_cmp_idx;
               end
               if (r_cmp_idx == IDX_W'(NCAND-1)) r_state <= DONE;
               else r_cmp_idx <= r_cmp_idx + 1'b1;
            end
            DONE: if (out_ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
